accel_dot_host: RTL and testbench

Host-side AXI4-Stream endpoint for the `accel_dot` accelerator: the transmitter for its input vector stream and the receiver for its output vector stream. Software or a test sequencer loads an N_IN-word input vector into a local buffer and pulses `start`. The block streams the vector out with TLAST on the final word, collects N_OUT result words into a result buffer and reports completion, protocol errors, timeout and the cycle count. It sits between a register/control front end and the accelerator's INPUT_AXIS/OUTPUT_AXIS ports.

---
 rtl/accel_dot_host.sv | 176 +++++++++++++++++
 tb/tb_accel_dot_host.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_dot_host.sv
// Host-side AXIS endpoint for accel_dot: streams a buffered input vector out and collects the result vector.
// Ideal latency N_IN+N_OUT cycles; TX holds TDATA/TLAST under TREADY backpressure, RX accepts one word per cycle.
module accel_dot_host #(
  parameter int N_IN    = 3,
  parameter int N_OUT   = 4,
  parameter int TIMEOUT = 4410,
  localparam int AW_IN  = (N_IN  > 1) ? $clog2(N_IN)  : 1,
  localparam int AW_OUT = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vec_wr_en,
  input  logic [AW_IN-1:0]  vec_wr_addr,
  input  logic [31:0]       vec_wr_data,
  input  logic [AW_OUT-1:0] res_rd_addr,
  output logic [31:0]       res_rd_data,
  output logic [31:0]       TX_AXIS_TDATA,
  output logic              TX_AXIS_TLAST,
  output logic              TX_AXIS_TVALID,
  input  logic              TX_AXIS_TREADY,
  input  logic [31:0]       RX_AXIS_TDATA,
  input  logic              RX_AXIS_TLAST,
  input  logic              RX_AXIS_TVALID,
  output logic              RX_AXIS_TREADY,
  output logic              busy,
  output logic              done,
  output logic              last_err,
  output logic              timeout,
  output logic [31:0]       cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [AW_IN-1:0]  tx_idx_q, tx_idx_d;
  logic [AW_OUT-1:0] rx_idx_q, rx_idx_d;
  logic              tx_vld_q, tx_vld_d;
  logic              tx_last_q, tx_last_d;
  logic [31:0]       tx_dat_q, tx_dat_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic              last_err_q, last_err_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       cycles_q, cycles_d;
  logic [31:0]       vec_q [N_IN];
  logic [31:0]       res_q [N_OUT];

  logic        tx_beat, rx_beat, rx_at_end, res_we, busy_w;
  logic [31:0] cyc_inc;

  assign busy_w    = (state_q == S_SEND) || (state_q == S_RECV);
  assign tx_beat   = tx_vld_q && TX_AXIS_TREADY;
  assign rx_beat   = rx_rdy_q && RX_AXIS_TVALID;
  assign rx_at_end = (rx_idx_q == AW_OUT'(N_OUT - 1));
  assign cyc_inc   = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
  assign res_we    = (state_q == S_RECV) && rx_beat;

  always_comb begin
    state_d    = state_q;
    tx_idx_d   = tx_idx_q;
    rx_idx_d   = rx_idx_q;
    tx_vld_d   = tx_vld_q;
    tx_last_d  = tx_last_q;
    tx_dat_d   = tx_dat_q;
    rx_rdy_d   = rx_rdy_q;
    last_err_d = last_err_q;
    timeout_d  = timeout_q;
    cycles_d   = cycles_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A vec write in the start cycle lands in the buffer, but word 0 is launched from the old contents.
        if (start) begin
          state_d    = S_SEND;
          tx_idx_d   = '0;
          rx_idx_d   = '0;
          last_err_d = 1'b0;
          timeout_d  = 1'b0;
          cycles_d   = '0;
          tx_vld_d   = 1'b1;
          tx_dat_d   = vec_q[0];
          tx_last_d  = (N_IN == 1);
        end
      end
      S_SEND: begin
        cycles_d = cyc_inc;
        if (tx_beat) begin
          if (tx_last_q) begin
            state_d   = S_RECV;
            tx_vld_d  = 1'b0;
            tx_last_d = 1'b0;
            tx_dat_d  = '0;
            rx_rdy_d  = 1'b1;
          end else begin
            tx_idx_d  = tx_idx_q + AW_IN'(1);
            tx_dat_d  = vec_q[tx_idx_d];
            tx_last_d = (tx_idx_d == AW_IN'(N_IN - 1));
          end
        end
      end
      S_RECV: begin
        cycles_d = cyc_inc;
        if (rx_beat) begin
          rx_idx_d = rx_idx_q + AW_OUT'(1);
          if (rx_at_end || RX_AXIS_TLAST) begin
            state_d    = S_DONE;
            rx_rdy_d   = 1'b0;
            last_err_d = (rx_at_end != RX_AXIS_TLAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort unless this very cycle completed the transaction normally.
    if (busy_w && (state_d != S_DONE) && (cyc_inc >= 32'(TIMEOUT))) begin
      state_d   = S_DONE;
      timeout_d = 1'b1;
      tx_vld_d  = 1'b0;
      tx_last_d = 1'b0;
      tx_dat_d  = '0;
      rx_rdy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_idx_q   <= '0;
      rx_idx_q   <= '0;
      tx_vld_q   <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_dat_q   <= '0;
      rx_rdy_q   <= 1'b0;
      last_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      tx_idx_q   <= tx_idx_d;
      rx_idx_q   <= rx_idx_d;
      tx_vld_q   <= tx_vld_d;
      tx_last_q  <= tx_last_d;
      tx_dat_q   <= tx_dat_d;
      rx_rdy_q   <= rx_rdy_d;
      last_err_q <= last_err_d;
      timeout_q  <= timeout_d;
      cycles_q   <= cycles_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) vec_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) res_q[k] <= '0;
    end else begin
      if (vec_wr_en && !busy_w && (32'(vec_wr_addr) < 32'(N_IN)))
        vec_q[vec_wr_addr] <= vec_wr_data;
      if (res_we)
        res_q[rx_idx_q] <= RX_AXIS_TDATA;
    end
  end

  assign res_rd_data    = (32'(res_rd_addr) < 32'(N_OUT)) ? res_q[res_rd_addr] : '0;
  assign TX_AXIS_TDATA  = tx_dat_q;
  assign TX_AXIS_TLAST  = tx_last_q;
  assign TX_AXIS_TVALID = tx_vld_q;
  assign RX_AXIS_TREADY = rx_rdy_q;
  assign busy           = busy_w;
  assign done           = (state_q == S_DONE);
  assign last_err       = last_err_q;
  assign timeout        = timeout_q;
  assign cycles         = cycles_q;

endmodule

// File: tb/tb_accel_dot_host.sv
// Randomized bench for accel_dot_host: AXIS sink/source responders plus a vector/result reference model.
module tb_accel_dot_host;
  localparam int N_IN  = 3;
  localparam int N_OUT = 4;
  localparam int TO    = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        vec_wr_en = 1'b0;
  logic [1:0]  vec_wr_addr = '0;
  logic [31:0] vec_wr_data = '0;
  logic [1:0]  res_rd_addr = '0;
  logic [31:0] res_rd_data;
  logic [31:0] TX_AXIS_TDATA;
  logic        TX_AXIS_TLAST, TX_AXIS_TVALID;
  logic        TX_AXIS_TREADY = 1'b1;
  logic [31:0] RX_AXIS_TDATA = '0;
  logic        RX_AXIS_TLAST = 1'b0;
  logic        RX_AXIS_TVALID = 1'b0;
  logic        RX_AXIS_TREADY;
  logic        busy, done, last_err, timeout;
  logic [31:0] cycles;

  accel_dot_host #(.N_IN(N_IN), .N_OUT(N_OUT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data),
    .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data),
    .TX_AXIS_TDATA(TX_AXIS_TDATA), .TX_AXIS_TLAST(TX_AXIS_TLAST),
    .TX_AXIS_TVALID(TX_AXIS_TVALID), .TX_AXIS_TREADY(TX_AXIS_TREADY),
    .RX_AXIS_TDATA(RX_AXIS_TDATA), .RX_AXIS_TLAST(RX_AXIS_TLAST),
    .RX_AXIS_TVALID(RX_AXIS_TVALID), .RX_AXIS_TREADY(RX_AXIS_TREADY),
    .busy(busy), .done(done), .last_err(last_err), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_vec [N_IN];
  logic [31:0] m_res [N_OUT];
  logic [31:0] rx_words [N_OUT];
  int          stall [N_IN];
  int          gap [N_OUT];
  int          tlast_at;
  int          rst_at;
  bit          rx_en, poke, ws;
  logic [31:0] ws_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input int a, input logic [31:0] d);
    vec_wr_en   = 1'b1;
    vec_wr_addr = 2'(a);
    vec_wr_data = d;
    tick();
    vec_wr_en = 1'b0;
    m_vec[a]  = d;
  endtask

  task automatic check_res(input string tag);
    for (int k = 0; k < N_OUT; k++) begin
      res_rd_addr = 2'(k);
      #1;
      check($sformatf("%s_res%0d", tag, k), res_rd_data, m_res[k]);
    end
  endtask

  task automatic set_defaults();
    for (int k = 0; k < N_IN; k++) stall[k] = 0;
    for (int k = 0; k < N_OUT; k++) gap[k] = 0;
    tlast_at = N_OUT - 1;
    rx_en    = 1'b1;
    poke     = 1'b0;
    ws       = 1'b0;
    rst_at   = -1;
  endtask

  // One transaction: expected cycles come from the stall/gap schedule, not from watching the DUT.
  task automatic run_txn(input string tag);
    logic [31:0] snap [N_IN];
    int i, j, sc, gc, cyc, exp_cyc, fin;
    bit rx_stop;
    snap  = m_vec;
    start = 1'b1;
    if (ws) begin
      vec_wr_en   = 1'b1;
      vec_wr_addr = 2'd0;
      vec_wr_data = ws_data;
    end
    tick();
    start     = 1'b0;
    vec_wr_en = 1'b0;
    if (ws) m_vec[0] = ws_data;
    i = 0; j = 0; sc = 0; gc = 0; cyc = 0; rx_stop = 1'b0;
    while (!done && cyc < 200) begin
      if (rst_at >= 0 && j == rst_at) break;
      start     = 1'b0;
      vec_wr_en = 1'b0;
      if (poke && cyc == 1) begin
        start       = 1'b1;
        vec_wr_en   = 1'b1;
        vec_wr_addr = 2'd0;
        vec_wr_data = ~snap[0];
      end
      TX_AXIS_TREADY = 1'b1;
      if (TX_AXIS_TVALID) begin
        if (i < N_IN) begin
          check($sformatf("%s_tx_dat%0d", tag, i), TX_AXIS_TDATA, snap[i]);
          check($sformatf("%s_tx_last%0d", tag, i), 32'(TX_AXIS_TLAST), 32'(i == N_IN - 1));
          if (sc < stall[i]) begin
            TX_AXIS_TREADY = 1'b0;
            sc++;
          end else begin
            i++;
            sc = 0;
          end
        end else begin
          check($sformatf("%s_tx_extra", tag), 32'(TX_AXIS_TVALID), 32'd0);
        end
      end
      RX_AXIS_TVALID = 1'b0;
      RX_AXIS_TLAST  = 1'b0;
      RX_AXIS_TDATA  = '0;
      if (RX_AXIS_TREADY && rx_en && !rx_stop) begin
        if (gc < gap[j]) begin
          gc++;
        end else begin
          res_rd_addr = 2'(j);
          #1;
          check($sformatf("%s_rd_old%0d", tag, j), res_rd_data, m_res[j]);
          RX_AXIS_TVALID = 1'b1;
          RX_AXIS_TDATA  = rx_words[j];
          RX_AXIS_TLAST  = (j == tlast_at);
          m_res[j] = rx_words[j];
          if (j == N_OUT - 1 || j == tlast_at) rx_stop = 1'b1;
          j++;
          gc = 0;
        end
      end
      tick();
      cyc++;
    end
    RX_AXIS_TVALID = 1'b0;
    RX_AXIS_TLAST  = 1'b0;
    TX_AXIS_TREADY = 1'b1;
    start          = 1'b0;
    vec_wr_en      = 1'b0;
    if (rst_at >= 0) return;
    check($sformatf("%s_done_wait", tag), 32'(done), 32'd1);
    fin = (tlast_at < N_OUT - 1) ? tlast_at : N_OUT - 1;
    if (!rx_en) begin
      exp_cyc = TO;
    end else begin
      exp_cyc = N_IN;
      for (int k = 0; k < N_IN; k++) exp_cyc += stall[k];
      for (int k = 0; k <= fin; k++) exp_cyc += 1 + gap[k];
    end
    check($sformatf("%s_cycles", tag), cycles, 32'(exp_cyc));
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_rx_rdy", tag), 32'(RX_AXIS_TREADY), 32'd0);
    check($sformatf("%s_tx_vld", tag), 32'(TX_AXIS_TVALID), 32'd0);
    check($sformatf("%s_last_err", tag), 32'(last_err), 32'(rx_en && tlast_at != N_OUT - 1));
    check($sformatf("%s_timeout", tag), 32'(timeout), 32'(!rx_en));
    check($sformatf("%s_tx_beats", tag), 32'(i), 32'(N_IN));
    check($sformatf("%s_rx_beats", tag), 32'(j), rx_en ? 32'(fin + 1) : 32'd0);
    check_res(tag);
  endtask

  task automatic load_case_a();
    load_vec(0, 32'h3DCCCCCD);
    load_vec(1, 32'h3E4CCCCD);
    load_vec(2, 32'h3E99999A);
    rx_words[0] = 32'h40733334;
    rx_words[1] = 32'h408CCCCD;
    rx_words[2] = 32'h40A00000;
    rx_words[3] = 32'h40B33334;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tx_vld"}, 32'(TX_AXIS_TVALID), 32'd0);
    check({tag, "_tx_dat"}, TX_AXIS_TDATA, 32'd0);
    check({tag, "_tx_last"}, 32'(TX_AXIS_TLAST), 32'd0);
    check({tag, "_rx_rdy"}, 32'(RX_AXIS_TREADY), 32'd0);
    check({tag, "_cycles"}, cycles, 32'd0);
    check({tag, "_last_err"}, 32'(last_err), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N_IN; k++) m_vec[k] = '0;
    for (int k = 0; k < N_OUT; k++) m_res[k] = '0;
    set_defaults();
    tick();
    tick();
    check_idle_zero("reset");
    rst = 1'b0;
    tick();
    check_idle_zero("post_reset");
    check_res("reset");

    load_case_a();
    run_txn("basic");

    set_defaults();
    stall[1] = 2;
    run_txn("stall");

    set_defaults();
    tlast_at = 1;
    rx_words[0] = 32'h11111111;
    rx_words[1] = 32'h22222222;
    run_txn("early_last");

    set_defaults();
    rx_en = 1'b0;
    run_txn("timeout");
    for (int k = 0; k < 3; k++) begin
      RX_AXIS_TVALID = 1'b1;
      RX_AXIS_TDATA  = 32'hBAD0BAD0;
      tick();
      check($sformatf("timeout_rdy_after%0d", k), 32'(RX_AXIS_TREADY), 32'd0);
      check($sformatf("timeout_done_after%0d", k), 32'(done), 32'd1);
    end
    RX_AXIS_TVALID = 1'b0;
    check_res("timeout_after");

    set_defaults();
    load_case_a();
    rst_at = 2;
    run_txn("mid_reset");
    #2 rst = 1'b1;
    #1;
    check_idle_zero("mid_reset");
    res_rd_addr = 2'd0;
    #1;
    check("mid_reset_res0", res_rd_data, 32'd0);
    for (int k = 0; k < N_IN; k++) m_vec[k] = '0;
    for (int k = 0; k < N_OUT; k++) m_res[k] = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    set_defaults();
    load_case_a();
    run_txn("after_reset");

    set_defaults();
    poke = 1'b1;
    run_txn("poke");
    set_defaults();
    run_txn("poke_check");

    set_defaults();
    ws = 1'b1;
    ws_data = 32'hDEADBEEF;
    run_txn("wr_start");
    set_defaults();
    run_txn("wr_start_check");

    for (int r = 0; r < 6; r++) begin
      set_defaults();
      for (int k = 0; k < N_IN; k++) begin
        load_vec(k, $urandom);
        stall[k] = $urandom_range(0, 2);
      end
      for (int k = 0; k < N_OUT; k++) begin
        rx_words[k] = $urandom;
        gap[k]      = $urandom_range(0, 1);
      end
      tlast_at = $urandom_range(0, N_OUT);
      run_txn($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
